// File: rtl/pll_reconfig_sequencer.sv
// Avalon-MM master that retunes one PLL C counter: writes Mode, C counter and Start,
// then polls Status until the PLL reports done or the poll budget runs out.
module pll_reconfig_sequencer #(
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_cidx,
  input  logic [7:0]  req_high,
  input  logic [7:0]  req_low,
  input  logic        req_bypass,
  input  logic        req_odd,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_read,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWrMode   = 3'd1;
  localparam logic [2:0] StWrC      = 3'd2;
  localparam logic [2:0] StWrStart  = 3'd3;
  localparam logic [2:0] StGap      = 3'd4;
  localparam logic [2:0] StRdStatus = 3'd5;
  localparam logic [2:0] StFinish   = 3'd6;

  localparam logic [15:0] PollMax = 16'(POLL_MAX);
  localparam logic [7:0]  GapLast = 8'(POLL_GAP - 1);

  logic [2:0]  state_q, state_d;
  logic [4:0]  cidx_q, cidx_d;
  logic [7:0]  high_q, high_d;
  logic [7:0]  low_q, low_d;
  logic        bypass_q, bypass_d;
  logic        odd_q, odd_d;
  logic [15:0] poll_q, poll_d;
  logic [7:0]  gap_q, gap_d;
  logic        ok_q, ok_d;
  logic [15:0] poll_inc;
  logic [31:0] c_word;
  logic        unused_rd;

  // Only the done flag of Status matters.
  assign unused_rd = ^mgmt_readdata[31:1];
  assign poll_inc  = poll_q + 16'd1;
  assign c_word    = {9'd0, cidx_q, odd_q, bypass_q, high_q, low_q};

  always_comb begin
    state_d  = state_q;
    cidx_d   = cidx_q;
    high_d   = high_q;
    low_d    = low_q;
    bypass_d = bypass_q;
    odd_d    = odd_q;
    poll_d   = poll_q;
    gap_d    = gap_q;
    ok_d     = ok_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          cidx_d   = req_cidx;
          high_d   = req_high;
          low_d    = req_low;
          bypass_d = req_bypass;
          odd_d    = req_odd;
          poll_d   = 16'd0;
          gap_d    = 8'd0;
          ok_d     = 1'b0;
          state_d  = StWrMode;
        end
      end
      StWrMode:  if (!mgmt_waitrequest) state_d = StWrC;
      StWrC:     if (!mgmt_waitrequest) state_d = StWrStart;
      StWrStart: if (!mgmt_waitrequest) state_d = StRdStatus;
      StRdStatus: begin
        if (!mgmt_waitrequest) begin
          poll_d = poll_inc;
          if (mgmt_readdata[0]) begin
            ok_d    = 1'b1;
            state_d = StFinish;
          end else if (poll_inc == PollMax) begin
            ok_d    = 1'b0;
            state_d = StFinish;
          end else begin
            gap_d   = 8'd0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StRdStatus;
        else                  gap_d   = gap_q + 8'd1;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= StIdle;
      cidx_q   <= 5'd0;
      high_q   <= 8'd0;
      low_q    <= 8'd0;
      bypass_q <= 1'b0;
      odd_q    <= 1'b0;
      poll_q   <= 16'd0;
      gap_q    <= 8'd0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cidx_q   <= cidx_d;
      high_q   <= high_d;
      low_q    <= low_d;
      bypass_q <= bypass_d;
      odd_q    <= odd_d;
      poll_q   <= poll_d;
      gap_q    <= gap_d;
      ok_q     <= ok_d;
    end
  end

  // Bus command is a pure decode of state, so it holds steady through any stall.
  always_comb begin
    mgmt_read      = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_address   = 6'h00;
    mgmt_writedata = 32'h0;
    case (state_q)
      StWrMode: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h00;
        mgmt_writedata = 32'h1;
      end
      StWrC: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h05;
        mgmt_writedata = c_word;
      end
      StWrStart: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h02;
        mgmt_writedata = 32'h1;
      end
      StRdStatus: begin
        mgmt_read    = 1'b1;
        mgmt_address = 6'h01;
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinish) && ok_q;
  assign timeout   = (state_q == StFinish) && !ok_q;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Scoreboard bench for pll_reconfig_sequencer: stimulus pushes expected bus cycles and
// pulses, a negedge monitor pops and compares them as the DUT produces them.
module tb_pll_reconfig_sequencer;

  localparam int unsigned PollGap = 4;
  localparam int unsigned PollMax = 3;

  localparam logic [7:0] KWr = 8'd0;
  localparam logic [7:0] KRd = 8'd1;
  localparam logic [7:0] KDone = 8'd2;
  localparam logic [7:0] KTmo = 8'd3;

  typedef struct {
    logic [7:0]  kind;
    logic [5:0]  addr;
    logic [31:0] data;
    int          lat;
    int          busyc;
  } exp_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_cidx = '0;
  logic [7:0]  req_high = '0;
  logic [7:0]  req_low = '0;
  logic        req_bypass = 1'b0;
  logic        req_odd = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic        mgmt_read;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata = '0;
  logic        busy;
  logic        done;
  logic        timeout;

  exp_t        expq[$];
  logic [31:0] statq[$];
  int          stall_n = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  pll_reconfig_sequencer #(.POLL_GAP(PollGap), .POLL_MAX(PollMax)) dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_cidx         (req_cidx),
    .req_high         (req_high),
    .req_low          (req_low),
    .req_bypass       (req_bypass),
    .req_odd          (req_odd),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_read        (mgmt_read),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .busy             (busy),
    .done             (done),
    .timeout          (timeout)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input logic [7:0] kind, input logic [5:0] addr, input logic [31:0] data,
                      input int lat, input int busyc);
    exp_t e;
    e.kind  = kind;
    e.addr  = addr;
    e.data  = data;
    e.lat   = lat;
    e.busyc = busyc;
    expq.push_back(e);
  endtask

  task automatic push_req(input logic [31:0] cword, input int n_reads, input logic [7:0] pulse,
                          input int lat);
    push(KWr, 6'h00, 32'h1, 0, 0);
    push(KWr, 6'h05, cword, 0, 0);
    push(KWr, 6'h02, 32'h1, 0, 0);
    for (int i = 0; i < n_reads; i++) push(KRd, 6'h01, 32'h0, 0, 0);
    push(pulse, 6'h00, 32'h0, lat, lat);
  endtask

  task automatic set_fields(input logic [4:0] c, input logic [7:0] h, input logic [7:0] l,
                            input logic b, input logic o);
    req_cidx   = c;
    req_high   = h;
    req_low    = l;
    req_bypass = b;
    req_odd    = o;
  endtask

  // Raises req_valid, waits for acceptance, then drops it.
  task automatic send(input logic [4:0] c, input logic [7:0] h, input logic [7:0] l,
                      input logic b, input logic o);
    int n;
    @(posedge clk_clk); #1;
    set_fields(c, h, l, b, o);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk_clk); #1;
      n++;
    end
    if (n >= 200) check("accept_timeout", 1, 0);
    @(posedge clk_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((expq.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk_clk);
      n++;
    end
    check(name, 64'(expq.size()), 0);
  endtask

  // Slave model: stalls every transfer for stall_n cycles, answers reads from statq.
  initial begin
    bit in_xfer;
    int wcnt;
    in_xfer = 1'b0;
    wcnt = 0;
    forever begin
      @(posedge clk_clk); #1;
      if (mgmt_read || mgmt_write) begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          wcnt = stall_n;
        end
        if (wcnt > 0) begin
          mgmt_waitrequest = 1'b1;
          wcnt--;
        end else begin
          mgmt_waitrequest = 1'b0;
          in_xfer = 1'b0;
          if (mgmt_read) mgmt_readdata = (statq.size() != 0) ? statq.pop_front() : 32'h1;
        end
      end else begin
        mgmt_waitrequest = 1'b0;
        in_xfer = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    bit          prev_stall, prev_cmd, after_read, ready_next, cmd;
    logic        p_rd, p_wr;
    logic [5:0]  p_addr;
    logic [31:0] p_data, act_data;
    int          idle_cnt, acc_cyc, busy_cnt;
    exp_t        e;
    prev_stall = 0; prev_cmd = 0; after_read = 0; ready_next = 0;
    idle_cnt = 0; acc_cyc = 0; busy_cnt = 0;
    p_rd = 0; p_wr = 0; p_addr = '0; p_data = '0;
    forever begin
      @(negedge clk_clk);
      if (reset_reset) begin
        prev_stall = 0; prev_cmd = 0; after_read = 0; ready_next = 0; idle_cnt = 0;
      end else begin
        cmd = mgmt_read || mgmt_write;
        if (ready_next) begin
          check("ready_after_pulse", 64'(req_ready), 1);
          ready_next = 0;
        end
        if (req_valid && req_ready) begin
          acc_cyc = cyc;
          busy_cnt = 0;
        end
        if (busy) busy_cnt++;
        if (mgmt_read && mgmt_write) check("rd_wr_exclusive", 1, 0);
        if (done && timeout) check("done_timeout_exclusive", 1, 0);
        if (prev_stall)
          check("stall_stable", {mgmt_read, mgmt_write, mgmt_address, mgmt_writedata},
                {p_rd, p_wr, p_addr, p_data});
        if (cmd && !prev_cmd && mgmt_read && after_read)
          check("poll_gap", 64'(idle_cnt), 64'(PollGap));
        if (cmd) idle_cnt = 0;
        else     idle_cnt++;
        if (cmd && !mgmt_waitrequest) begin
          if (expq.size() == 0) begin
            check("unexpected_xfer", {mgmt_write, mgmt_address}, 0);
          end else begin
            e = expq.pop_front();
            act_data = mgmt_write ? mgmt_writedata : 32'h0;
            check(mgmt_write ? "write" : "read", {mgmt_write ? KWr : KRd, mgmt_address, act_data},
                  {e.kind, e.addr, e.data});
          end
          after_read = mgmt_read;
        end
        if (done || timeout) begin
          if (expq.size() == 0) begin
            check("unexpected_pulse", {done, timeout}, 0);
          end else begin
            e = expq.pop_front();
            check("pulse_kind", done ? KDone : KTmo, e.kind);
            check("pulse_latency", 64'(cyc - acc_cyc), 64'(e.lat));
            check("busy_cycles", 64'(busy_cnt), 64'(e.busyc));
          end
          ready_next = 1;
          after_read = 0;
        end
        prev_stall = cmd && mgmt_waitrequest;
        prev_cmd = cmd;
        p_rd = mgmt_read;
        p_wr = mgmt_write;
        p_addr = mgmt_address;
        p_data = mgmt_writedata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    check("rst_req_ready", 64'(req_ready), 1);
    check("rst_read", 64'(mgmt_read), 0);
    check("rst_write", 64'(mgmt_write), 0);
    check("rst_address", 64'(mgmt_address), 0);
    check("rst_writedata", 64'(mgmt_writedata), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done_timeout", {done, timeout}, 0);
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;

    // Basic retune, immediate completion.
    stall_n = 0;
    statq.push_back(32'h0000_0001);
    push_req(32'h000C_0A0A, 1, KDone, 5);
    send(5'd3, 8'h0A, 8'h0A, 1'b0, 1'b0);
    drain("t1_drain");

    // Three wait states on every transfer.
    stall_n = 3;
    statq.push_back(32'h0000_0001);
    push_req(32'h000C_0A0A, 1, KDone, 17);
    send(5'd3, 8'h0A, 8'h0A, 1'b0, 1'b0);
    drain("t2_drain");
    stall_n = 0;

    // Two not-done polls (upper bits set, must be ignored) then done.
    statq.push_back(32'hFFFF_FFFE);
    statq.push_back(32'hFFFF_FFFE);
    statq.push_back(32'h0000_0001);
    push_req(32'h000C_0A0A, 3, KDone, 15);
    send(5'd3, 8'h0A, 8'h0A, 1'b0, 1'b0);
    drain("t3_drain");

    // Never done: timeout after PollMax reads.
    statq.push_back(32'h0);
    statq.push_back(32'h0);
    statq.push_back(32'h0);
    push_req(32'h000C_0A0A, 3, KTmo, 15);
    send(5'd3, 8'h0A, 8'h0A, 1'b0, 1'b0);
    drain("t4_drain");

    // Fields churn while busy; second request carries its own fields.
    statq.push_back(32'h1);
    statq.push_back(32'h1);
    push_req(32'h000C_0A0A, 1, KDone, 5);
    push_req(32'h0047_0504, 1, KDone, 5);
    @(posedge clk_clk); #1;
    set_fields(5'd3, 8'h0A, 8'h0A, 1'b0, 1'b0);
    req_valid = 1'b1;
    @(posedge clk_clk); #1;
    set_fields(5'd9, 8'hFF, 8'h33, 1'b1, 1'b0);
    @(posedge clk_clk); #1;
    set_fields(5'd1, 8'h77, 8'hEE, 1'b0, 1'b1);
    @(posedge clk_clk); #1;
    set_fields(5'd17, 8'h05, 8'h04, 1'b1, 1'b1);
    begin
      int n;
      n = 0;
      while (!req_ready && n < 200) begin
        @(posedge clk_clk); #1;
        n++;
      end
      check("t5_second_ready", 64'(req_ready), 1);
    end
    @(posedge clk_clk); #1;
    req_valid = 1'b0;
    drain("t5_drain");

    // Reset in the middle of a stalled C write.
    stall_n = 10;
    push(KWr, 6'h00, 32'h1, 0, 0);
    send(5'd3, 8'h0A, 8'h0A, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (!(mgmt_write && mgmt_address == 6'h05 && mgmt_waitrequest) && n < 200) begin
        @(negedge clk_clk);
        n++;
      end
      check("t6_reached_wr_c", 64'(mgmt_address), 64'h05);
    end
    #1;
    reset_reset = 1'b1;
    @(negedge clk_clk);
    check("t6_write_low", 64'(mgmt_write), 0);
    check("t6_ready", 64'(req_ready), 1);
    check("t6_busy", 64'(busy), 0);
    check("t6_no_pulse", {done, timeout}, 0);
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;
    stall_n = 0;
    repeat (5) @(negedge clk_clk);
    check("t6_stays_idle", {req_ready, busy, done, timeout, mgmt_write, mgmt_read}, 6'b100000);
    drain("final_queue_empty");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
